// File: rtl/fb_draw_arbiter.sv
// Round-robin arbiter that grants the shared framebuffer write port to one of
// four fill-rectangle requesters and rasterises the granted rectangle.
module fb_draw_arbiter #(
  parameter int LINE_WIDTH = 800,
  parameter int H_MIN      = 144,
  parameter int H_MAX      = 783,
  parameter int V_MIN      = 35,
  parameter int V_MAX      = 514
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [39:0] cmd_x0,
  input  logic [39:0] cmd_y0,
  input  logic [39:0] cmd_x1,
  input  logic [39:0] cmd_y1,
  input  logic [11:0] cmd_color,
  input  logic        wr_ready,
  output logic        wr_en,
  output logic [18:0] wr_addr,
  output logic [11:0] wr_data,
  output logic [3:0]  gnt,
  output logic [3:0]  done,
  output logic        err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t     state_reg;
  logic [1:0] rr_ptr_reg;
  logic [1:0] owner_reg;
  logic [9:0] x0_reg;
  logic [9:0] y0_reg;
  logic [9:0] x1_reg;
  logic [9:0] y1_reg;
  logic [9:0] cx_reg;
  logic [9:0] cy_reg;
  logic [2:0] color_reg;
  logic       reject_reg;

  logic [9:0] x0_arr [4];
  logic [9:0] y0_arr [4];
  logic [9:0] x1_arr [4];
  logic [9:0] y1_arr [4];
  logic [2:0] col_arr [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_split
    assign x0_arr[gi]  = cmd_x0[10*gi +: 10];
    assign y0_arr[gi]  = cmd_y0[10*gi +: 10];
    assign x1_arr[gi]  = cmd_x1[10*gi +: 10];
    assign y1_arr[gi]  = cmd_y1[10*gi +: 10];
    assign col_arr[gi] = cmd_color[3*gi +: 3];
  end

  // Search upward from rr_ptr; iterating from the far end lets the nearest hit win.
  logic       sel_valid;
  logic [1:0] sel_idx;
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = rr_ptr_reg;
    for (int k = 3; k >= 0; k--) begin
      if (req[rr_ptr_reg + 2'(k)]) begin
        sel_valid = 1'b1;
        sel_idx   = rr_ptr_reg + 2'(k);
      end
    end
  end

  logic [9:0] sel_x0;
  logic [9:0] sel_y0;
  logic [9:0] sel_x1;
  logic [9:0] sel_y1;
  logic       cmd_ok;
  assign sel_x0 = x0_arr[sel_idx];
  assign sel_y0 = y0_arr[sel_idx];
  assign sel_x1 = x1_arr[sel_idx];
  assign sel_y1 = y1_arr[sel_idx];
  assign cmd_ok = (sel_x0 >= 10'(H_MIN)) && (sel_x0 <= sel_x1) && (sel_x1 <= 10'(H_MAX)) &&
                  (sel_y0 >= 10'(V_MIN)) && (sel_y0 <= sel_y1) && (sel_y1 <= 10'(V_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= 2'd0;
      owner_reg  <= 2'd0;
      x0_reg     <= 10'd0;
      y0_reg     <= 10'd0;
      x1_reg     <= 10'd0;
      y1_reg     <= 10'd0;
      cx_reg     <= 10'd0;
      cy_reg     <= 10'd0;
      color_reg  <= 3'd0;
      reject_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (sel_valid) begin
            owner_reg  <= sel_idx;
            x0_reg     <= sel_x0;
            y0_reg     <= sel_y0;
            x1_reg     <= sel_x1;
            y1_reg     <= sel_y1;
            cx_reg     <= sel_x0;
            cy_reg     <= sel_y0;
            color_reg  <= col_arr[sel_idx];
            reject_reg <= !cmd_ok;
            state_reg  <= cmd_ok ? WRITE : DONE;
          end
        end
        WRITE: begin
          // Without an accept, the current pixel simply holds.
          if (wr_ready) begin
            if (cx_reg != x1_reg) begin
              cx_reg <= cx_reg + 10'd1;
            end else if (cy_reg != y1_reg) begin
              cx_reg <= x0_reg;
              cy_reg <= cy_reg + 10'd1;
            end else begin
              state_reg <= DONE;
            end
          end
        end
        DONE: begin
          rr_ptr_reg <= owner_reg + 2'd1;
          state_reg  <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  logic [3:0] owner_onehot;
  assign owner_onehot = 4'b0001 << owner_reg;

  assign busy    = (state_reg != IDLE);
  assign wr_en   = (state_reg == WRITE);
  assign gnt     = busy ? owner_onehot : 4'b0000;
  assign done    = (state_reg == DONE) ? owner_onehot : 4'b0000;
  assign err     = (state_reg == DONE) && reject_reg;
  assign wr_addr = 19'(cy_reg) * 19'(LINE_WIDTH) + 19'(cx_reg);

  always_comb begin
    case (color_reg)
      3'd1:    wr_data = 12'hF00;
      3'd2:    wr_data = 12'h0F0;
      3'd3:    wr_data = 12'h00F;
      3'd4:    wr_data = 12'hFFF;
      default: wr_data = 12'h000;
    endcase
  end

endmodule

// File: doc/fb_draw_arbiter.md
Name: fb_draw_arbiter

Overview:
- Shares the single framebuffer write port between 4 shape-drawing requesters.
- Picks one pending fill-rectangle command by round-robin, latches it, then scans the rectangle raster-order: one pixel write per accepted cycle.
- Write address is y*LINE_WIDTH + x, with 12-bit RGB data.
- Sits between the draw FSMs and the framebuffer RAM write port.

Parameters:
- LINE_WIDTH, 800, total pixels per line including blanking (address stride).
- H_MIN, 144, first visible horizontal coordinate.
- H_MAX, 783, last visible horizontal coordinate.
- V_MIN, 35, first visible vertical coordinate.
- V_MAX, 514, last visible vertical coordinate.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  4  per-requester command request; held high until its done pulse.
- cmd_x0  in  40  4x10-bit left edge; requester i uses bits [10i+9:10i].
- cmd_y0  in  40  4x10-bit top edge.
- cmd_x1  in  40  4x10-bit right edge (inclusive).
- cmd_y1  in  40  4x10-bit bottom edge (inclusive).
- cmd_color  in  12  4x3-bit colour code.
- wr_ready  in  1  framebuffer accepts a write this cycle.
- wr_en  out  1  write strobe.
- wr_addr  out  19  framebuffer write address.
- wr_data  out  12  RGB444 pixel.
- gnt  out  4  one-hot, owner of the port; held from latch through DONE.
- done  out  4  one-cycle completion pulse to the owner.
- err  out  1  one-cycle pulse, coincident with done, when the command was rejected.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset: state IDLE; rr_ptr=0; wr_en, gnt, done, err, busy all 0; wr_addr, wr_data 0.
  - Reset is asynchronous: asserting it mid-WRITE drops wr_en immediately.
  - The command in progress is discarded and no done is issued.
- States: IDLE, WRITE, DONE.
- IDLE:
  - If any req bit is high, select the first set bit searching upward from rr_ptr, wrapping 3->0.
  - On that edge: latch x0, y0, x1, y1 and colour; set cx=x0, cy=y0; assert gnt.
  - Go to WRITE if the command is valid, else go to DONE with the reject flag set.
- Valid command: H_MIN<=x0<=x1<=H_MAX and V_MIN<=y0<=y1<=V_MAX. Anything else is rejected with no writes.
- WRITE:
  - wr_en=1, wr_addr=cy*LINE_WIDTH+cx, wr_data=palette(colour); all decoded from registers, so there is no combinational path from req.
  - On wr_en && wr_ready:
    - If cx!=x1: cx++.
    - Else if cy!=y1: cx=x0, cy++.
    - Else: go to DONE.
  - wr_ready low: addr and data held, nothing advances, no pixel skipped or repeated.
- DONE (one cycle):
  - wr_en=0; done[owner]=1; err=reject flag.
  - Next edge: rr_ptr=owner+1 (mod 4), gnt=0, back to IDLE.
- Latency:
  - First wr_en is 1 cycle after the req-sampling edge.
  - done pulses the cycle after the last accepted write.
  - A new grant can start the cycle after DONE.
- Requests:
  - Changes to req or cmd of the owner after the latch are ignored.
  - Requests arriving while busy wait their turn.
- Palette: 0=000, 1=F00, 2=0F0, 3=00F, 4=FFF (hex); codes 5-7 map to 000.
- Arithmetic:
  - Multiply is unsigned and 19 bits wide.
  - The largest address, 514*800+783=411983, fits without overflow.

Test Plan:
- Red 2x2 rectangle (req[0]=1, x 144..145, y 35..36, colour 1, wr_ready=1) -> wr_addr sequence 28144, 28145, 28944, 28945 with wr_data=F00; then done[0] for 1 cycle, gnt[0] low the cycle after.
- Round-robin: req=1111, all single-pixel commands -> grants in order 0, 1, 2, 3, each with one write and one done. With rr_ptr back at 0, re-request req=1001 -> grant 0 then 3.
- Stall: 3x1 rectangle with wr_ready low for 3 cycles after the first accept -> wr_addr stays at the 2nd pixel throughout the stall; exactly 3 writes total; no duplicate addresses.
- Reject:
  - x0=146, x1=145 -> no wr_en; done+err one cycle after grant.
  - x0=143 -> the same response.
- Corner: single pixel (783,514), colour 4 -> one write, addr 411983, data FFF.
- Reset mid-WRITE (rst pulsed during the 2nd pixel of a 4-pixel fill) -> wr_en, gnt, busy 0 asynchronously; no done. After release, with req still high, the same requester is regranted and the fill restarts at its first pixel.
